// File: rtl/count_mon_pkg.sv
// Shared types and default widths for the counter wrap-around monitor.
package count_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } mon_state_t;

    localparam int CNT_W_DEF  = 4;
    localparam int WRAP_W_DEF = 8;

endpackage

// File: rtl/wrap_detect.sv
// Remembers the previous enabled count sample and flags a wrap when the
// count moves backwards (modulo 2^CNT_W) between two consecutive enabled samples.
module wrap_detect
    import count_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] count_in,
    output logic             wrap
);

    logic [CNT_W-1:0] prev_q;
    logic             prev_valid;

    // Previous-sample register; validity drops whenever monitoring pauses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_valid <= enable;
            if (enable) begin
                prev_q <= count_in;
            end
        end
    end

    assign wrap = enable & prev_valid & (count_in < prev_q);

endmodule

// File: rtl/count_wrap_monitor.sv
// Counts wrap-arounds of a free-running counter into a saturating accumulator
// and raises a held alarm when the accumulator reaches a programmable level.
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  count_in,
    input  logic [WRAP_W-1:0] threshold,
    input  logic              alarm_ack,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              alarm,
    output logic              overflow,
    output logic [1:0]        state
);

    mon_state_t        state_r;
    mon_state_t        state_next_s;
    logic [WRAP_W-1:0] wrap_count_r;
    logic [WRAP_W-1:0] count_base_s;
    logic [WRAP_W:0]   count_inc_s;
    logic [WRAP_W-1:0] count_next_s;
    logic              overflow_r;
    logic              overflow_next_s;
    logic              wrap_pulse_r;
    logic              alarm_r;
    logic              wrap_s;
    logic              ack_clear_s;
    logic              thr_hit_s;

    wrap_detect #(.CNT_W(CNT_W)) u_wrap_detect (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .count_in (count_in),
        .wrap     (wrap_s)
    );

    // Accumulator update: an acknowledge clears first, then a coincident wrap counts.
    always_comb begin
        ack_clear_s     = (state_r == ALARM) && alarm_ack;
        count_base_s    = ack_clear_s ? '0 : wrap_count_r;
        count_inc_s     = {1'b0, count_base_s} + {{WRAP_W{1'b0}}, 1'b1};
        count_next_s    = count_base_s;
        overflow_next_s = overflow_r;
        if (wrap_s) begin
            if (count_inc_s[WRAP_W]) begin
                overflow_next_s = 1'b1;
            end else begin
                count_next_s = count_inc_s[WRAP_W-1:0];
            end
        end else begin
            count_next_s = count_base_s;
        end
        thr_hit_s = (threshold != '0) && (count_next_s >= threshold);
    end

    // Next-state logic; ALARM is left only through an acknowledge.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_next_s = ARMED;
                else        state_next_s = IDLE;
            end
            ARMED: begin
                if (!enable)        state_next_s = IDLE;
                else if (thr_hit_s) state_next_s = ALARM;
                else                state_next_s = ARMED;
            end
            ALARM: begin
                if (alarm_ack) state_next_s = enable ? ARMED : IDLE;
                else           state_next_s = ALARM;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            wrap_count_r <= '0;
            overflow_r   <= 1'b0;
            wrap_pulse_r <= 1'b0;
            alarm_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            wrap_count_r <= count_next_s;
            overflow_r   <= overflow_next_s;
            wrap_pulse_r <= wrap_s;
            alarm_r      <= (state_next_s == ALARM);
        end
    end

    assign wrap_pulse = wrap_pulse_r;
    assign wrap_count = wrap_count_r;
    assign alarm      = alarm_r;
    assign overflow   = overflow_r;
    assign state      = state_r;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed self-checking bench for count_wrap_monitor with hand-computed expectations.
module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic [7:0] threshold = 8'd0;
    logic       alarm_ack = 1'b0;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       alarm;
    logic       overflow;
    logic [1:0] state;

    int checks_cnt = 0;
    int errors_cnt = 0;

    count_wrap_monitor #(.CNT_W(4), .WRAP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .count_in   (count_in),
        .threshold  (threshold),
        .alarm_ack  (alarm_ack),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .alarm      (alarm),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v);
        count_in = v;
        tick();
    endtask

    logic [3:0] step3_seq [11] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5, 4'd7, 4'd7, 4'd7};

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            enable    = 1'($urandom_range(0, 1));
            alarm_ack = 1'($urandom_range(0, 1));
            count_in  = 4'($urandom_range(0, 15));
            threshold = 8'($urandom_range(0, 255));
            tick();
            check_eq("reset_outs", {20'd0, wrap_pulse, wrap_count, alarm, overflow, state}, 32'd0);
        end
        enable = 1'b0; alarm_ack = 1'b0; threshold = 8'd0; count_in = 4'd0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_disabled", {30'd0, state}, 32'd0);
        end

        // Basic +1 sweep then wrap to 0
        enable = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            drive(4'(i));
            check_eq("basic_pulse", {31'd0, wrap_pulse}, (i == 16) ? 32'd1 : 32'd0);
        end
        check_eq("basic_count", {24'd0, wrap_count}, 32'd1);
        check_eq("basic_alarm", {31'd0, alarm}, 32'd0);
        check_eq("basic_state", {30'd0, state}, 32'd1);

        // Step of 3 then repeated values
        for (int i = 0; i < 11; i++) begin
            drive(step3_seq[i]);
            check_eq("step3_pulse", {31'd0, wrap_pulse}, (i == 6) ? 32'd1 : 32'd0);
        end
        check_eq("step3_count", {24'd0, wrap_count}, 32'd2);

        // Threshold lowered to current count -> alarm next clk
        threshold = 8'd2;
        drive(4'd7);
        check_eq("thr_drop_state", {30'd0, state}, 32'd2);
        check_eq("thr_drop_alarm", {31'd0, alarm}, 32'd1);
        check_eq("thr_drop_pulse", {31'd0, wrap_pulse}, 32'd0);
        alarm_ack = 1'b1;
        drive(4'd7);
        alarm_ack = 1'b0;
        check_eq("ack_alarm", {31'd0, alarm}, 32'd0);
        check_eq("ack_count", {24'd0, wrap_count}, 32'd0);
        check_eq("ack_state", {30'd0, state}, 32'd1);

        // Two wraps reach threshold 2
        drive(4'd8);
        drive(4'd0);
        check_eq("w1_pulse", {31'd0, wrap_pulse}, 32'd1);
        check_eq("w1_count", {24'd0, wrap_count}, 32'd1);
        check_eq("w1_alarm", {31'd0, alarm}, 32'd0);
        drive(4'd8);
        check_eq("w1b_pulse", {31'd0, wrap_pulse}, 32'd0);
        drive(4'd0);
        check_eq("w2_pulse", {31'd0, wrap_pulse}, 32'd1);
        check_eq("w2_alarm", {31'd0, alarm}, 32'd1);
        check_eq("w2_state", {30'd0, state}, 32'd2);
        check_eq("w2_count", {24'd0, wrap_count}, 32'd2);

        // Ack coincident with a wrap
        drive(4'd8);
        check_eq("hold_state", {30'd0, state}, 32'd2);
        alarm_ack = 1'b1;
        drive(4'd0);
        alarm_ack = 1'b0;
        check_eq("ackwrap_count", {24'd0, wrap_count}, 32'd1);
        check_eq("ackwrap_pulse", {31'd0, wrap_pulse}, 32'd1);
        check_eq("ackwrap_state", {30'd0, state}, 32'd1);
        check_eq("ackwrap_alarm", {31'd0, alarm}, 32'd0);
        drive(4'd1);
        check_eq("rearm_state", {30'd0, state}, 32'd1);
        check_eq("rearm_count", {24'd0, wrap_count}, 32'd1);

        // Enable dropped at 14, resumed at 2
        drive(4'd13);
        drive(4'd14);
        enable = 1'b0;
        drive(4'd15);
        check_eq("dis_state", {30'd0, state}, 32'd0);
        check_eq("dis_count", {24'd0, wrap_count}, 32'd1);
        drive(4'd0);
        check_eq("dis_pulse", {31'd0, wrap_pulse}, 32'd0);
        enable = 1'b1;
        drive(4'd2);
        check_eq("reen_pulse", {31'd0, wrap_pulse}, 32'd0);
        check_eq("reen_state", {30'd0, state}, 32'd1);
        drive(4'd3);
        check_eq("reen2_pulse", {31'd0, wrap_pulse}, 32'd0);
        drive(4'd0);
        check_eq("reen_wrap_pulse", {31'd0, wrap_pulse}, 32'd1);
        check_eq("reen_wrap_alarm", {31'd0, alarm}, 32'd1);
        enable = 1'b0;
        drive(4'd0);
        check_eq("alarm_kept_state", {30'd0, state}, 32'd2);
        check_eq("alarm_kept_alarm", {31'd0, alarm}, 32'd1);

        // Asynchronous reset while alarmed
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_outs", {20'd0, wrap_pulse, wrap_count, alarm, overflow, state}, 32'd0);
        tick();
        reset = 1'b1; enable = 1'b1; threshold = 8'd0;
        drive(4'd5);
        check_eq("post_rst_pulse", {31'd0, wrap_pulse}, 32'd0);
        check_eq("post_rst_state", {30'd0, state}, 32'd1);

        // Saturation: 255 wraps fill, 256th overflows
        for (int k = 1; k <= 255; k++) begin
            drive(4'd6);
            drive(4'd0);
            if (k == 1 || k == 255) begin
                check_eq("sat_pulse", {31'd0, wrap_pulse}, 32'd1);
                check_eq("sat_count", {24'd0, wrap_count}, 32'(k));
                check_eq("sat_ovf_low", {31'd0, overflow}, 32'd0);
            end
        end
        drive(4'd6);
        drive(4'd0);
        check_eq("ovf_pulse", {31'd0, wrap_pulse}, 32'd1);
        check_eq("ovf_count", {24'd0, wrap_count}, 32'd255);
        check_eq("ovf_set", {31'd0, overflow}, 32'd1);
        threshold = 8'd200;
        drive(4'd6);
        check_eq("ovf_alarm_state", {30'd0, state}, 32'd2);
        alarm_ack = 1'b1;
        drive(4'd6);
        alarm_ack = 1'b0;
        check_eq("ovf_ack_count", {24'd0, wrap_count}, 32'd0);
        check_eq("ovf_ack_sticky", {31'd0, overflow}, 32'd1);
        drive(4'd6);
        check_eq("ovf_still", {31'd0, overflow}, 32'd1);
        reset = 1'b0;
        tick();
        check_eq("ovf_rst", {31'd0, overflow}, 32'd0);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
